// File: rtl/cvxif_issue_tracker.sv
// CV-X-IF issue front end: decodes offloaded instructions, holds them in an
// ID-tagged queue until commit/kill, and forwards committed ones in order.
package cvxif_issue_tracker_pkg;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] mask;
        logic        accept;
        logic        writeback;
        logic [2:0]  register_read;
        logic [7:0]  opcode;
    } decode_entry_t;

    // NOP (custom-3), ROR64H/ROR64L (custom-0 f3=0, f7=0/1), ASCON (f3=1), CHACHA (f3=2)
    localparam decode_entry_t DefaultDecodeTable [5] = '{
        '{instr: 32'h0000_007B, mask: 32'hFFFF_FFFF, accept: 1'b1, writeback: 1'b0, register_read: 3'b000, opcode: 8'd1},
        '{instr: 32'h0000_000B, mask: 32'hFE00_707F, accept: 1'b1, writeback: 1'b1, register_read: 3'b011, opcode: 8'd2},
        '{instr: 32'h0200_000B, mask: 32'hFE00_707F, accept: 1'b1, writeback: 1'b1, register_read: 3'b011, opcode: 8'd3},
        '{instr: 32'h0000_100B, mask: 32'h0000_707F, accept: 1'b1, writeback: 1'b1, register_read: 3'b001, opcode: 8'd4},
        '{instr: 32'h0000_200B, mask: 32'h0000_707F, accept: 1'b1, writeback: 1'b1, register_read: 3'b111, opcode: 8'd5}
    };

endpackage

module cvxif_issue_tracker
    import cvxif_issue_tracker_pkg::*;
#(
    parameter int            NbInstr     = 5,
    parameter int            Depth       = 4,
    parameter int            IdWidth     = 3,
    parameter int            OpcodeWidth = 4,
    parameter decode_entry_t DecodeTable [NbInstr] = DefaultDecodeTable
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     issue_valid_i,
    output logic                     issue_ready_o,
    input  logic [31:0]              issue_instr_i,
    input  logic [IdWidth-1:0]       issue_id_i,
    input  logic [2:0]               issue_rs_valid_i,
    input  logic [2:0][31:0]         issue_rs_i,
    output logic                     issue_accept_o,
    output logic                     issue_writeback_o,
    output logic [2:0]               issue_register_read_o,
    input  logic                     commit_valid_i,
    input  logic [IdWidth-1:0]       commit_id_i,
    input  logic                     commit_kill_i,
    output logic                     dispatch_valid_o,
    input  logic                     dispatch_ready_i,
    output logic [OpcodeWidth-1:0]   dispatch_opcode_o,
    output logic [IdWidth-1:0]       dispatch_id_o,
    output logic [31:0]              dispatch_instr_o,
    output logic [2:0][31:0]         dispatch_rs_o,
    output logic                     dispatch_writeback_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int PtrWidth = $clog2(Depth);
    localparam int CntWidth = PtrWidth + 1;

    typedef struct packed {
        logic                   valid;
        logic                   committed;
        logic                   killed;
        logic [IdWidth-1:0]     id;
        logic [OpcodeWidth-1:0] opcode;
        logic                   writeback;
        logic [31:0]            instr;
        logic [2:0][31:0]       rs;
    } entry_t;

    entry_t                q_q [Depth];
    logic [PtrWidth-1:0]   head_q, tail_q;
    logic [CntWidth-1:0]   count_q;

    logic                   hit, dec_accept, dec_writeback;
    logic [2:0]             dec_rr;
    logic [OpcodeWidth-1:0] dec_opcode;
    logic                   id_live, full, push, pop;

    // Lowest matching index wins: only the first hit is taken.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        hit           = 1'b0;
        dec_accept    = 1'b0;
        dec_writeback = 1'b0;
        dec_rr        = '0;
        dec_opcode    = '0;
        for (int i = 0; i < NbInstr; i++) begin
            if (!hit && ((issue_instr_i & DecodeTable[i].mask) == DecodeTable[i].instr)) begin
                hit           = 1'b1;
                dec_accept    = DecodeTable[i].accept;
                dec_writeback = DecodeTable[i].writeback;
                dec_rr        = DecodeTable[i].register_read;
                dec_opcode    = DecodeTable[i].opcode[OpcodeWidth-1:0];
            end
        end
    end

    always_comb begin
        id_live = 1'b0;
        for (int i = 0; i < Depth; i++) begin
            if (q_q[i].valid && (q_q[i].id == issue_id_i)) id_live = 1'b1;
        end
    end

    // Full uses the registered count, so a same-cycle pop never frees room for a push.
    assign full          = (count_q == CntWidth'(Depth));
    assign issue_ready_o = !full && !id_live &&
                           (!hit || ((issue_rs_valid_i & dec_rr) == dec_rr));
    assign push          = issue_valid_i && issue_ready_o && dec_accept;
    assign pop           = q_q[head_q].valid &&
                           (q_q[head_q].killed || (q_q[head_q].committed && dispatch_ready_i));

    assign issue_accept_o        = dec_accept;
    assign issue_writeback_o     = dec_writeback;
    assign issue_register_read_o = dec_rr;

    assign dispatch_valid_o     = q_q[head_q].valid && q_q[head_q].committed && !q_q[head_q].killed;
    assign dispatch_opcode_o    = q_q[head_q].opcode;
    assign dispatch_id_o        = q_q[head_q].id;
    assign dispatch_instr_o     = q_q[head_q].instr;
    assign dispatch_rs_o        = q_q[head_q].rs;
    assign dispatch_writeback_o = q_q[head_q].writeback;
    assign count_o              = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the queue storage is reset too, so dispatch data reads as zero out of reset.
            for (int i = 0; i < Depth; i++) q_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            // NOTE: non-blocking updates; later statements below override earlier ones on the same slot.
            if (commit_valid_i) begin
                for (int i = 0; i < Depth; i++) begin
                    if (q_q[i].valid && (q_q[i].id == commit_id_i)) begin
                        if (commit_kill_i) q_q[i].killed    <= 1'b1;
                        else               q_q[i].committed <= 1'b1;
                    end
                end
            end
            if (pop) begin
                q_q[head_q] <= '0;
                head_q      <= head_q + PtrWidth'(1);
            end
            if (push) begin
                q_q[tail_q] <= '{valid: 1'b1, committed: 1'b0, killed: 1'b0, id: issue_id_i,
                                 opcode: dec_opcode, writeback: dec_writeback,
                                 instr: issue_instr_i, rs: issue_rs_i};
                tail_q      <= tail_q + PtrWidth'(1);
            end
            count_q <= count_q + CntWidth'(push) - CntWidth'(pop);
        end
    end

endmodule

// File: tb/tb_cvxif_issue_tracker.sv
// Self-checking bench for cvxif_issue_tracker: decode vector table, directed
// multi-cycle sequences, and randomized traffic against a queue-based model.
module tb_cvxif_issue_tracker;

    localparam int Depth = 4;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             issue_valid_i;
    logic             issue_ready_o;
    logic [31:0]      issue_instr_i;
    logic [2:0]       issue_id_i;
    logic [2:0]       issue_rs_valid_i;
    logic [2:0][31:0] issue_rs_i;
    logic             issue_accept_o;
    logic             issue_writeback_o;
    logic [2:0]       issue_register_read_o;
    logic             commit_valid_i;
    logic [2:0]       commit_id_i;
    logic             commit_kill_i;
    logic             dispatch_valid_o;
    logic             dispatch_ready_i;
    logic [3:0]       dispatch_opcode_o;
    logic [2:0]       dispatch_id_o;
    logic [31:0]      dispatch_instr_o;
    logic [2:0][31:0] dispatch_rs_o;
    logic             dispatch_writeback_o;
    logic [2:0]       count_o;

    cvxif_issue_tracker dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .issue_valid_i         (issue_valid_i),
        .issue_ready_o         (issue_ready_o),
        .issue_instr_i         (issue_instr_i),
        .issue_id_i            (issue_id_i),
        .issue_rs_valid_i      (issue_rs_valid_i),
        .issue_rs_i            (issue_rs_i),
        .issue_accept_o        (issue_accept_o),
        .issue_writeback_o     (issue_writeback_o),
        .issue_register_read_o (issue_register_read_o),
        .commit_valid_i        (commit_valid_i),
        .commit_id_i           (commit_id_i),
        .commit_kill_i         (commit_kill_i),
        .dispatch_valid_o      (dispatch_valid_o),
        .dispatch_ready_i      (dispatch_ready_i),
        .dispatch_opcode_o     (dispatch_opcode_o),
        .dispatch_id_o         (dispatch_id_o),
        .dispatch_instr_o      (dispatch_instr_o),
        .dispatch_rs_o         (dispatch_rs_o),
        .dispatch_writeback_o  (dispatch_writeback_o),
        .count_o               (count_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic to_neg();
        @(negedge clk_i);
    endtask

    task automatic to_pos();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid_i    = 1'b0;
        issue_instr_i    = '0;
        issue_id_i       = '0;
        issue_rs_valid_i = '0;
        issue_rs_i       = '0;
        commit_valid_i   = 1'b0;
        commit_id_i      = '0;
        commit_kill_i    = 1'b0;
        dispatch_ready_i = 1'b0;
    endtask

    // Reference decode written from instruction fields rather than mask/match pairs.
    typedef struct packed {
        logic       hit;
        logic       wb;
        logic [2:0] rr;
        logic [3:0] op;
    } mdec_t;

    function automatic mdec_t model_decode(input logic [31:0] w);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        opc = w[6:0];
        f3  = w[14:12];
        f7  = w[31:25];
        if (w == 32'h0000_007B)                            return '{1'b1, 1'b0, 3'b000, 4'd1};
        if (opc == 7'h0B && f3 == 3'd0 && f7 == 7'd0)      return '{1'b1, 1'b1, 3'b011, 4'd2};
        if (opc == 7'h0B && f3 == 3'd0 && f7 == 7'd1)      return '{1'b1, 1'b1, 3'b011, 4'd3};
        if (opc == 7'h0B && f3 == 3'd1)                    return '{1'b1, 1'b1, 3'b001, 4'd4};
        if (opc == 7'h0B && f3 == 3'd2)                    return '{1'b1, 1'b1, 3'b111, 4'd5};
        return '{1'b0, 1'b0, 3'b000, 4'd0};
    endfunction

    typedef struct {
        logic [2:0]       id;
        logic [3:0]       op;
        logic [31:0]      instr;
        logic [2:0][31:0] rs;
        logic             wb;
        logic             committed;
        logic             killed;
    } mentry_t;

    mentry_t mq[$];

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  rs_valid;
        logic        acc;
        logic        wb;
        logic [2:0]  rr;
        logic        ready;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int got_ids[3];
        int n;
        int exp_order[3];

        vecs[0]  = '{32'h0000_007B, 3'b000, 1'b1, 1'b0, 3'b000, 1'b1};
        vecs[1]  = '{32'h00C5_850B, 3'b001, 1'b1, 1'b1, 3'b011, 1'b0};
        vecs[2]  = '{32'h00C5_850B, 3'b011, 1'b1, 1'b1, 3'b011, 1'b1};
        vecs[3]  = '{32'h02C5_850B, 3'b111, 1'b1, 1'b1, 3'b011, 1'b1};
        vecs[4]  = '{32'h0000_100B, 3'b000, 1'b1, 1'b1, 3'b001, 1'b0};
        vecs[5]  = '{32'h0000_200B, 3'b011, 1'b1, 1'b1, 3'b111, 1'b0};
        vecs[6]  = '{32'h0000_200B, 3'b111, 1'b1, 1'b1, 3'b111, 1'b1};
        vecs[7]  = '{32'h0000_0033, 3'b000, 1'b0, 1'b0, 3'b000, 1'b1};
        vecs[8]  = '{32'h0000_007F, 3'b000, 1'b0, 1'b0, 3'b000, 1'b1};
        vecs[9]  = '{32'h0000_300B, 3'b000, 1'b0, 1'b0, 3'b000, 1'b1};
        vecs[10] = '{32'h0400_000B, 3'b000, 1'b0, 1'b0, 3'b000, 1'b1};

        // Reset state
        idle_inputs();
        rst_ni = 1'b0;
        #12;
        check("rst_count", count_o, 0);
        check("rst_dvalid", dispatch_valid_o, 0);
        check("rst_dop", dispatch_opcode_o, 0);
        check("rst_did", dispatch_id_o, 0);
        check("rst_dinstr", dispatch_instr_o, 0);
        check("rst_drs", dispatch_rs_o, 0);
        check("rst_dwb", dispatch_writeback_o, 0);
        to_neg();
        rst_ni = 1'b1;
        to_pos();

        // Decode table vectors (no handshake, empty queue)
        foreach (vecs[i]) begin
            issue_instr_i    = vecs[i].instr;
            issue_rs_valid_i = vecs[i].rs_valid;
            issue_id_i       = 3'd5;
            #1;
            check($sformatf("vec%0d_accept", i), issue_accept_o, vecs[i].acc);
            check($sformatf("vec%0d_wb", i), issue_writeback_o, vecs[i].wb);
            check($sformatf("vec%0d_rr", i), issue_register_read_o, vecs[i].rr);
            check($sformatf("vec%0d_ready", i), issue_ready_o, vecs[i].ready);
        end
        idle_inputs();
        to_pos();

        // NOP issue, commit, dispatch one cycle after commit
        dispatch_ready_i = 1'b1;
        issue_valid_i    = 1'b1;
        issue_instr_i    = 32'h0000_007B;
        issue_id_i       = 3'd1;
        issue_rs_valid_i = 3'b000;
        to_neg();
        check("nop_ready", issue_ready_o, 1);
        check("nop_accept", issue_accept_o, 1);
        check("nop_wb", issue_writeback_o, 0);
        check("nop_rr", issue_register_read_o, 0);
        to_pos();
        issue_valid_i = 1'b0;
        to_neg();
        check("nop_count1", count_o, 1);
        check("nop_dv_precommit", dispatch_valid_o, 0);
        to_pos();
        commit_valid_i = 1'b1;
        commit_id_i    = 3'd1;
        to_pos();
        commit_valid_i = 1'b0;
        to_neg();
        check("nop_dv", dispatch_valid_o, 1);
        check("nop_dop", dispatch_opcode_o, 1);
        check("nop_did", dispatch_id_o, 1);
        check("nop_dinstr", dispatch_instr_o, 32'h0000_007B);
        check("nop_dwb", dispatch_writeback_o, 0);
        to_pos();
        to_neg();
        check("nop_count0", count_o, 0);
        check("nop_dv_after", dispatch_valid_o, 0);
        to_pos();
        dispatch_ready_i = 1'b0;

        // ROR64H waits for rs2
        issue_valid_i    = 1'b1;
        issue_instr_i    = 32'h00C5_850B;
        issue_id_i       = 3'd2;
        issue_rs_valid_i = 3'b001;
        to_neg();
        check("ror_ready_wait", issue_ready_o, 0);
        check("ror_rr", issue_register_read_o, 3'b011);
        to_pos();
        issue_rs_valid_i = 3'b011;
        to_neg();
        check("ror_ready", issue_ready_o, 1);
        check("ror_wb", issue_writeback_o, 1);
        to_pos();
        idle_inputs();
        to_neg();
        check("ror_count", count_o, 1);
        to_pos();
        commit_valid_i = 1'b1;
        commit_id_i    = 3'd2;
        commit_kill_i  = 1'b1;
        to_pos();
        idle_inputs();
        to_neg();
        check("ror_killed_dv", dispatch_valid_o, 0);
        to_pos();
        to_neg();
        check("ror_killed_count", count_o, 0);
        to_pos();

        // Illegal ADD completes handshake but is not enqueued
        issue_valid_i = 1'b1;
        issue_instr_i = 32'h0000_0033;
        issue_id_i    = 3'd3;
        to_neg();
        check("add_ready", issue_ready_o, 1);
        check("add_accept", issue_accept_o, 0);
        to_pos();
        idle_inputs();
        to_neg();
        check("add_count", count_o, 0);
        check("add_dv", dispatch_valid_o, 0);
        to_pos();

        // Fill, out-of-order commit/kill, in-order dispatch
        for (int id = 0; id < 4; id++) begin
            issue_valid_i    = 1'b1;
            issue_instr_i    = 32'h0000_100B;
            issue_id_i       = 3'(id);
            issue_rs_valid_i = 3'b001;
            issue_rs_i       = {32'hC0 + 32'(id), 32'hB0 + 32'(id), 32'hA0 + 32'(id)};
            to_neg();
            check($sformatf("fill%0d_ready", id), issue_ready_o, 1);
            to_pos();
        end
        issue_id_i = 3'd4;
        to_neg();
        check("full_count", count_o, 4);
        check("full_ready", issue_ready_o, 0);
        to_pos();
        idle_inputs();
        exp_order = '{1, 2, 3};
        begin
            int cids[4];
            logic ckill[4];
            cids  = '{2, 0, 1, 3};
            ckill = '{1'b0, 1'b1, 1'b0, 1'b0};
            for (int k = 0; k < 4; k++) begin
                commit_valid_i = 1'b1;
                commit_id_i    = 3'(cids[k]);
                commit_kill_i  = ckill[k];
                to_pos();
            end
        end
        idle_inputs();
        dispatch_ready_i = 1'b1;
        n = 0;
        got_ids = '{-1, -1, -1};
        for (int c = 0; c < 12; c++) begin
            to_neg();
            if (dispatch_valid_o) begin
                if (n < 3) begin
                    got_ids[n] = int'(dispatch_id_o);
                    check($sformatf("order%0d_rs1", n), dispatch_rs_o[0], 32'hA0 + 32'(exp_order[n]));
                end
                n++;
            end
            to_pos();
        end
        check("order_count", n, 3);
        for (int k = 0; k < 3; k++) check($sformatf("order%0d_id", k), got_ids[k], exp_order[k]);
        check("order_empty", count_o, 0);
        idle_inputs();

        // Live-ID stall, unknown commit, held dispatch
        issue_valid_i = 1'b1;
        issue_instr_i = 32'h0000_007B;
        issue_id_i    = 3'd2;
        to_pos();
        commit_valid_i = 1'b1;
        commit_id_i    = 3'd7;
        to_neg();
        check("live_ready", issue_ready_o, 0);
        check("live_count", count_o, 1);
        to_pos();
        commit_valid_i = 1'b0;
        to_neg();
        check("unknown_count", count_o, 1);
        check("unknown_dv", dispatch_valid_o, 0);
        to_pos();
        commit_valid_i = 1'b1;
        commit_id_i    = 3'd2;
        to_pos();
        commit_valid_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            to_neg();
            check($sformatf("hold%0d_dv", c), dispatch_valid_o, 1);
            check($sformatf("hold%0d_id", c), dispatch_id_o, 2);
            check($sformatf("hold%0d_op", c), dispatch_opcode_o, 1);
            check($sformatf("hold%0d_instr", c), dispatch_instr_o, 32'h0000_007B);
            check($sformatf("hold%0d_ready", c), issue_ready_o, 0);
            to_pos();
        end
        dispatch_ready_i = 1'b1;
        to_neg();
        check("live_pop_ready", issue_ready_o, 0);
        to_pos();
        dispatch_ready_i = 1'b0;
        to_neg();
        check("live_free_ready", issue_ready_o, 1);
        check("live_free_count", count_o, 0);
        to_pos();
        issue_id_i = 3'd5;
        to_pos();
        idle_inputs();
        commit_valid_i = 1'b1;
        commit_id_i    = 3'd2;
        to_pos();
        idle_inputs();

        // Asynchronous reset mid-stream
        to_neg();
        check("pre_rst_count", count_o, 2);
        check("pre_rst_dv", dispatch_valid_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("mid_rst_count", count_o, 0);
        check("mid_rst_dv", dispatch_valid_o, 0);
        check("mid_rst_did", dispatch_id_o, 0);
        check("mid_rst_dinstr", dispatch_instr_o, 0);
        to_neg();
        rst_ni = 1'b1;
        mq.delete();
        to_pos();

        // Randomized traffic against the queue model
        for (int cyc = 0; cyc < 400; cyc++) begin
            mdec_t   d;
            logic    live;
            logic    exp_ready;
            logic    exp_dv;
            int      k;
            int      cand[$];
            mentry_t e;

            issue_valid_i = ($urandom_range(0, 1) == 1);
            issue_id_i    = 3'($urandom_range(0, 7));
            k = $urandom_range(0, 5);
            case (k)
                0: issue_instr_i = 32'h0000_007B;
                1: issue_instr_i = ($urandom & ~32'hFE00_707F) | 32'h0000_000B;
                2: issue_instr_i = ($urandom & ~32'hFE00_707F) | 32'h0200_000B;
                3: issue_instr_i = ($urandom & ~32'h0000_707F) | 32'h0000_100B;
                4: issue_instr_i = ($urandom & ~32'h0000_707F) | 32'h0000_200B;
                default: issue_instr_i = $urandom;
            endcase
            issue_rs_valid_i = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'($urandom_range(0, 7));
            issue_rs_i       = {$urandom, $urandom, $urandom};
            commit_valid_i   = ($urandom_range(0, 9) < 4);
            commit_kill_i    = ($urandom_range(0, 3) == 0);
            foreach (mq[i]) if (!mq[i].committed && !mq[i].killed) cand.push_back(i);
            if (cand.size() > 0 && $urandom_range(0, 4) != 0)
                commit_id_i = mq[cand[$urandom_range(0, cand.size() - 1)]].id;
            else
                commit_id_i = 3'($urandom_range(0, 7));
            dispatch_ready_i = ($urandom_range(0, 9) < 7);

            to_neg();
            d    = model_decode(issue_instr_i);
            live = 1'b0;
            foreach (mq[i]) if (mq[i].id == issue_id_i) live = 1'b1;
            exp_ready = (mq.size() < Depth) && !live &&
                        (!d.hit || ((issue_rs_valid_i & d.rr) == d.rr));
            exp_dv = (mq.size() > 0) && mq[0].committed && !mq[0].killed;
            check("rnd_accept", issue_accept_o, d.hit);
            check("rnd_wb", issue_writeback_o, d.wb);
            check("rnd_rr", issue_register_read_o, d.rr);
            check("rnd_ready", issue_ready_o, exp_ready);
            check("rnd_count", count_o, mq.size());
            check("rnd_dv", dispatch_valid_o, exp_dv);
            if (exp_dv) begin
                check("rnd_dop", dispatch_opcode_o, mq[0].op);
                check("rnd_did", dispatch_id_o, mq[0].id);
                check("rnd_dinstr", dispatch_instr_o, mq[0].instr);
                check("rnd_drs", dispatch_rs_o, mq[0].rs);
                check("rnd_dwb", dispatch_writeback_o, mq[0].wb);
            end

            if (mq.size() > 0 && (mq[0].killed || (mq[0].committed && dispatch_ready_i)))
                void'(mq.pop_front());
            if (commit_valid_i) begin
                foreach (mq[i]) begin
                    if (mq[i].id == commit_id_i) begin
                        e = mq[i];
                        if (commit_kill_i) e.killed = 1'b1;
                        else               e.committed = 1'b1;
                        mq[i] = e;
                    end
                end
            end
            if (issue_valid_i && exp_ready && d.hit) begin
                e = '{issue_id_i, d.op, issue_instr_i, issue_rs_i, d.wb, 1'b0, 1'b0};
                mq.push_back(e);
            end
            to_pos();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cvxif_issue_tracker.md
Name: cvxif_issue_tracker

Overview:
- Parametrised CV-X-IF issue front end for the crypto coprocessor.
- Decodes offloaded instructions against a configurable mask/match table, lowest matching index wins.
- Answers the issue handshake, then buffers accepted instructions in an ID-tagged queue until the core commits or kills them.
- Forwards committed instructions in order to the execution units (ROR64, ASCON, CHACHA); kill and commit arrive by ID, in any order.

Parameters:
- NbInstr, 5: number of decode table entries.
- Depth, 4: outstanding-instruction queue depth (power of two, ≥2).
- IdWidth, 3: width of the CV-X-IF instruction ID.
- OpcodeWidth, 4: width of the internal opcode handed to execution.
- DecodeTable, default 5-entry custom table (NOP, ROR64H, ROR64L, OP_ASCON, OP_CHACHA): per entry instr[31:0], mask[31:0], accept, writeback, register_read[2:0], opcode.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- issue_valid_i  in  1  core offers an instruction.
- issue_ready_o  out  1  tracker can take the offered instruction this cycle.
- issue_instr_i  in  32  offered instruction word.
- issue_id_i  in  IdWidth  instruction ID.
- issue_rs_valid_i  in  3  rs1/rs2/rs3 operand valid.
- issue_rs_i  in  3x32  operand values.
- issue_accept_o  out  1  decode hit; valid while issue_valid_i is high.
- issue_writeback_o  out  1  matched entry writes rd.
- issue_register_read_o  out  3  matched entry reads rs1/rs2/rs3.
- commit_valid_i  in  1  commit event.
- commit_id_i  in  IdWidth  ID being committed.
- commit_kill_i  in  1  1 = discard, 0 = execute.
- dispatch_valid_o  out  1  head entry committed and ready for execution.
- dispatch_ready_i  in  1  execution unit takes the head entry.
- dispatch_opcode_o  out  OpcodeWidth  decoded opcode.
- dispatch_id_o  out  IdWidth  ID of the head entry.
- dispatch_instr_o  out  32  instruction word of the head entry.
- dispatch_rs_o  out  3x32  captured operands.
- dispatch_writeback_o  out  1  head entry writes rd.
- count_o  out  $clog2(Depth)+1  occupied entries.

Behaviour:
- Reset: everything is asynchronous on rst_ni low.
  - Queue empties; all valid, committed and killed flags clear.
  - count_o = 0, dispatch_valid_o = 0; all dispatch data outputs = 0.
- Decode (combinational):
  - hit = any entry with (issue_instr_i & mask) == instr.
  - On no hit: accept, writeback and register_read outputs are 0 and opcode is ILLEGAL (0).
- issue_ready_o = !full && !id_live(issue_id_i) && (!hit || (issue_rs_valid_i & register_read) == register_read).
  - id_live means a valid queue entry already holds that ID.
  - Full is evaluated on the registered count; a same-cycle dispatch pop does not free a slot for the push.
- Issue transaction = issue_valid_i && issue_ready_o.
  - Accepted (hit) instructions push at the tail with operands captured and committed = killed = 0; the entry is visible next cycle.
  - Illegal instructions complete the handshake with accept = 0 and are not enqueued.
- Commit:
  - On commit_valid_i, every valid entry with matching ID gets committed = 1, or killed = 1 if commit_kill_i; this takes effect next cycle.
  - An unknown ID is ignored.
  - A commit naming an ID being pushed in the same cycle is ignored; the core never does this legally.
- Head handling:
  - Killed head: popped without dispatch, one per cycle; dispatch_valid_o stays 0.
  - Committed, non-killed head: dispatch_valid_o = 1. It pops on dispatch_ready_i, and outputs hold stable until then.
  - Uncommitted head: blocks, even if later entries are committed.
- Push and pop in the same cycle: count unchanged; pointers wrap modulo Depth.
- Flag updates apply only to valid entries; a popped slot is cleared when freed.
- Reset mid-operation discards all entries with no dispatch.

Test Plan:
- NOP 0x0000007B, id 1, rs_valid 000 → ready = 1, accept = 1, writeback = 0, rr = 000; commit id 1 → dispatch opcode NOP (1), id 1, one cycle after commit.
- ROR64H 0x00C5850B, rs_valid 001 → ready = 0 (rr = 011); raise rs_valid to 011 → handshake, writeback = 1, count_o = 1.
- 0x00000033 (ADD) → ready = 1, accept = 0, opcode ILLEGAL; count_o stays 0 and nothing is dispatched.
- Fill with IDs 0–3 → count_o = 4, ready = 0 for id 4; commit id 2, kill id 0, commit id 1, commit id 3 → dispatches 1, 2, 3 in order; id 0 is never dispatched.
- Issue with id 2 while id 2 is live → ready = 0 until id 2 pops; commit unknown id 7 → no state change.
- Hold dispatch_ready_i = 0 with head committed → outputs stable for 10 cycles; assert rst_ni low mid-stream → count_o = 0 and dispatch_valid_o = 0 immediately.
